axi4l_decoder: RTL and testbench
================================

# axi4l_decoder

AXI4-Lite 1-to-N address decoder between the CPU-side AXI4-Lite master and the peripheral slaves (LED, UART, timer, ...). It routes each write and read to one slave by address window, answers unmapped addresses itself with DECERR, and returns the slave's response to the master. There is one outstanding write and one outstanding read, and the write and read paths are fully independent.

## Interface
Parameters:
- N = 4 — number of slave ports, 1..16.
- BASE = 32'h8000_0000 — peripheral region base; bits [15:0] must be zero.
- TIMEOUT = 255 — response watchdog limit in cycles; only used with the timeout feature.

Ports:
- aclk  input  1  — clock; all logic on rising edge.
- areset  input  1  — synchronous, active-high reset.
- s  axi4l_if.slave  —  — upstream master side.
- m[N]  axi4l_if.master  —  — downstream slave ports.
- The interfaces' own aclk/aresetn are not used.

## Operation
- Address decode:
  - Mapped when addr[31:16] == BASE[31:16] and idx = addr[15:12] < N.
  - Mapped addresses select m[idx].
  - The address is forwarded unchanged; the slave uses [11:0].
- Write FSM states: W_IDLE, W_REQ, W_RESP, W_BRESP.
  - W_IDLE:
    - s.awready = 1 until AW is captured; s.wready = 1 until W is captured.
    - Captured addr, data and strb are registered; AW and W may arrive in any order or together.
    - When both are held: mapped → W_REQ; unmapped → W_BRESP with DECERR.
  - W_REQ:
    - Drive m[idx].awvalid and m[idx].wvalid from the registers.
    - Each valid drops after its own handshake.
    - When both have completed → W_RESP.
  - W_RESP: m[idx].bready = 1. On m[idx].bvalid, capture bresp → W_BRESP.
  - W_BRESP: s.bvalid = 1 with the registered bresp. On s.bready → W_IDLE.
- Read FSM states: R_IDLE, R_REQ, R_RESP, R_DATA. Same structure as the write FSM.
  - R_IDLE: s.arready = 1.
  - R_REQ: m[idx].arvalid held until handshake.
  - R_RESP: m[idx].rready = 1; capture rdata and rresp.
  - R_DATA: s.rvalid = 1 until s.rready.
  - Unmapped reads: rdata = 0, rresp = DECERR.
- Unselected m[k] valids are 0.
- Every m[k].bready (m[k].rready) is 1 whenever the write (read) FSM is not in W_RESP (R_RESP). This drains stray responses.
- Read and write to the same slave proceed concurrently.

## Timing
- Reset values:
  - All FSMs go to IDLE.
  - s.bvalid = s.rvalid = 0.
  - All m[k].awvalid/wvalid/arvalid = 0.
  - s.awready = s.wready = s.arready = 1.
  - Response registers are cleared to OKAY/0.
- An areset asserted mid-transaction aborts it. All valids are low from the next cycle, and in-flight data is discarded.
- Write with AW+W handshaken in cycle 0 to a zero-wait slave:
  - m.awvalid/wvalid in cycle 1.
  - Slave bvalid in cycle 2.
  - s.bvalid in cycle 3.
- Read has the same latency: arvalid in cycle 0 → s.rvalid in cycle 3.
- Unmapped access: s.bvalid/s.rvalid in cycle 1.
- AW in cycle 0 and W in cycle 2: request starts in cycle 3.
- The s.* ready signals are low from W_REQ until return to W_IDLE (and the read equivalent). There is no new acceptance while a response is pending.
- s.bvalid/s.rvalid, once asserted, stay stable until the handshake.

## Configuration
- AXI4L_DECODER_TIMEOUT_EN defined:
  - An 8..16-bit counter is cleared on entry to W_REQ/R_REQ and increments each cycle in REQ/RESP.
  - Reaching TIMEOUT forces SLVERR to W_BRESP/R_DATA (rdata = 0) and deasserts slave valids.
  - A late slave response is drained via the idle bready/rready rule.
- Undefined: no counter. The FSM waits indefinitely for the slave.

## Structure
- axi4l_pkg (shared):
  - resp_t gets DECERR and SLVERR if missing.
  - Add PERIPH_WIN_BITS = 12 and the decode-field localparams.
- Natural sub-module: axi4l_decoder_chan, instantiated twice (write and read). It contains the generic IDLE/REQ/RESP/RSP FSM, the index register and the timeout counter.

## Test plan
- Write 0x5 to BASE+0x0000 (m[0] = LED slave) → m[0] sees awaddr 0x8000_0000 and wdata 0x5; s.bvalid in cycle 3 with OKAY; led = 4'h5.
- Read BASE+0x1004 with m[1] returning 0xDEAD_BEEF → s.rdata = 0xDEAD_BEEF, OKAY; no valid on m[0], m[2] or m[3].
- Write to 0x8000_F000 (idx 15 ≥ N) and read 0x9000_0000 → DECERR in cycle 1; rdata = 0; no m[k] activity.
- W at cycle 0, AW at cycle 2, s.bready low for 3 cycles → s.bvalid and bresp stay stable; W_IDLE re-entered only after the handshake.
- Concurrent read and write to m[2]; areset pulsed while in W_RESP → all valids 0 next cycle; a subsequent write completes normally.
- With AXI4L_DECODER_TIMEOUT_EN, TIMEOUT = 8, and m[3] never asserting bvalid → SLVERR on s.b after 8 cycles; a later bvalid from m[3] is absorbed without a second s.bvalid.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types, peripheral-window decode fields and helpers.
// Used by the decoder, its channel FSM and the bus interface.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_REQ,
    C_RESP,
    C_RSP
  } chan_state_t;

  localparam int PERIPH_WIN_BITS = 12;
  localparam int IDX_LSB         = PERIPH_WIN_BITS;
  localparam int IDX_W           = 4;
  localparam int REGION_LSB      = IDX_LSB + IDX_W;
  localparam int CNT_W           = 16;

  function automatic logic addr_mapped(
    input logic [31:0] a,
    input logic [31:0] base,
    input int          n
  );
    return (a[31:REGION_LSB] == base[31:REGION_LSB])
        && (int'(a[IDX_LSB +: IDX_W]) < n);
  endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bus bundle with master/slave views.
// Clock and reset are supplied to the endpoints directly.
interface axi4l_if;
  import axi4l_pkg::*;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  resp_t       bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  resp_t       rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4l_decoder_chan.sv
// One decoder channel: IDLE/REQ/RESP/RSP FSM, captured address, timeout.
// AXI4L_DECODER_TIMEOUT_EN adds the response watchdog counter.
module axi4l_decoder_chan
  import axi4l_pkg::*;
#(
  parameter int          N       = 4,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          TIMEOUT = 255,
  parameter int          RW      = 2,
  parameter bit          HAS_D   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [31:0]      a_addr,
  output logic             a_ready,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [31:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             a_req,
  output logic             d_req,
  input  logic             a_done,
  input  logic             d_done,
  output logic             rsp_wait,
  input  logic             rsp_valid,
  input  logic [RW-1:0]    rsp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_rsp
);

  chan_state_t state, state_n;
  logic a_held, d_held, a_pend, d_pend;
  logic a_fire, d_fire, a_all, d_all;
  logic hit, expired;

  assign idx    = addr[IDX_LSB +: IDX_W];
  assign a_fire = a_valid && a_ready;
  assign d_fire = d_valid && d_ready;
  assign a_all  = a_held || a_fire;
  assign d_all  = d_held || d_fire || !HAS_D;
  assign hit    = addr_mapped(a_held ? addr : a_addr, BASE, N);

`ifdef AXI4L_DECODER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || (state != C_REQ && state_n == C_REQ))
      cnt <= '0;
    else if (state == C_REQ || state == C_RESP)
      cnt <= cnt + CNT_W'(1);
  end

  assign expired = cnt >= CNT_W'(TIMEOUT - 1);
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT;
  assign expired    = 1'b0;
`endif

  always_comb begin
    state_n = state;
    a_ready = 1'b0;
    d_ready = 1'b0;
    unique case (state)
      C_IDLE: begin
        a_ready = !a_held;
        d_ready = HAS_D && !d_held;
        if (a_all && d_all)
          state_n = hit ? C_REQ : C_RSP;
      end
      C_REQ: begin
        if ((!a_pend || a_done) && (!d_pend || d_done))
          state_n = C_RESP;
        else if (expired)
          state_n = C_RSP;
      end
      C_RESP: begin
        if (rsp_valid || expired)
          state_n = C_RSP;
      end
      C_RSP: begin
        if (out_ready)
          state_n = C_IDLE;
      end
      default: state_n = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= C_IDLE;
      a_held  <= 1'b0;
      d_held  <= 1'b0;
      a_pend  <= 1'b0;
      d_pend  <= 1'b0;
      addr    <= '0;
      out_rsp <= '0;
    end else begin
      state <= state_n;
      if (a_fire)
        addr <= a_addr;
      unique case (state)
        C_IDLE: begin
          if (state_n != C_IDLE) begin
            a_held <= 1'b0;
            d_held <= 1'b0;
            a_pend <= 1'b1;
            d_pend <= HAS_D;
          end else begin
            a_held <= a_all;
            d_held <= d_held || d_fire;
          end
          if (state_n == C_RSP)
            out_rsp <= RW'(DECERR);
        end
        C_REQ: begin
          if (a_done)
            a_pend <= 1'b0;
          if (d_done)
            d_pend <= 1'b0;
          if (state_n == C_RSP)
            out_rsp <= RW'(SLVERR);
        end
        C_RESP: begin
          if (rsp_valid)
            out_rsp <= rsp_in;
          else if (state_n == C_RSP)
            out_rsp <= RW'(SLVERR);
        end
        default: ;
      endcase
    end
  end

  assign a_req     = (state == C_REQ) && a_pend;
  assign d_req     = (state == C_REQ) && d_pend;
  assign rsp_wait  = (state == C_RESP);
  assign out_valid = (state == C_RSP);

endmodule

// File: rtl/axi4l_decoder.sv
// AXI4-Lite 1-to-N address decoder with DECERR for unmapped addresses.
// AXI4L_DECODER_TIMEOUT_EN enables the per-channel response watchdog.
module axi4l_decoder
  import axi4l_pkg::*;
#(
  parameter int          N       = 4,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          TIMEOUT = 255
) (
  input  logic     aclk,
  input  logic     areset,
  axi4l_if.slave   s,
  axi4l_if.master  m [N]
);

  localparam int WRW = 2;
  localparam int RRW = 34;

  logic [15:0]      awready_v, wready_v, bvalid_v;
  logic [15:0]      arready_v, rvalid_v;
  resp_t            bresp_a [16];
  resp_t            rresp_a [16];
  logic [31:0]      rdata_a [16];
  logic [31:0]      waddr, raddr, wdata;
  logic [3:0]       wstrb;
  logic [IDX_W-1:0] widx, ridx;
  logic             aw_req, w_req, b_wait;
  logic             ar_req, r_wait;
  logic             rd_d_ready, rd_d_req;
  logic [WRW-1:0]   wr_rsp;
  logic [RRW-1:0]   rd_rsp;
  logic             unused_rd;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wdata <= '0;
      wstrb <= '0;
    end else if (s.wvalid && s.wready) begin
      wdata <= s.wdata;
      wstrb <= s.wstrb;
    end
  end

  axi4l_decoder_chan #(
    .N(N), .BASE(BASE), .TIMEOUT(TIMEOUT),
    .RW(WRW), .HAS_D(1'b1)
  ) u_wr (
    .clk(aclk), .rst(areset),
    .a_valid(s.awvalid), .a_addr(s.awaddr),
    .a_ready(s.awready),
    .d_valid(s.wvalid), .d_ready(s.wready),
    .addr(waddr), .idx(widx),
    .a_req(aw_req), .d_req(w_req),
    .a_done(awready_v[widx]), .d_done(wready_v[widx]),
    .rsp_wait(b_wait),
    .rsp_valid(bvalid_v[widx]), .rsp_in(bresp_a[widx]),
    .out_valid(s.bvalid), .out_ready(s.bready),
    .out_rsp(wr_rsp)
  );

  axi4l_decoder_chan #(
    .N(N), .BASE(BASE), .TIMEOUT(TIMEOUT),
    .RW(RRW), .HAS_D(1'b0)
  ) u_rd (
    .clk(aclk), .rst(areset),
    .a_valid(s.arvalid), .a_addr(s.araddr),
    .a_ready(s.arready),
    .d_valid(1'b0), .d_ready(rd_d_ready),
    .addr(raddr), .idx(ridx),
    .a_req(ar_req), .d_req(rd_d_req),
    .a_done(arready_v[ridx]), .d_done(1'b0),
    .rsp_wait(r_wait),
    .rsp_valid(rvalid_v[ridx]),
    .rsp_in({rdata_a[ridx], rresp_a[ridx]}),
    .out_valid(s.rvalid), .out_ready(s.rready),
    .out_rsp(rd_rsp)
  );

  assign s.bresp    = resp_t'(wr_rsp);
  assign s.rdata    = rd_rsp[RRW-1:2];
  assign s.rresp    = resp_t'(rd_rsp[1:0]);
  assign unused_rd  = rd_d_ready | rd_d_req;

  // Ports beyond N read as idle so the 4-bit index never leaves the table.
  for (genvar k = 0; k < 16; k++) begin : g_port
    if (k < N) begin : g_on
      assign awready_v[k] = m[k].awready;
      assign wready_v[k]  = m[k].wready;
      assign bvalid_v[k]  = m[k].bvalid;
      assign bresp_a[k]   = m[k].bresp;
      assign arready_v[k] = m[k].arready;
      assign rvalid_v[k]  = m[k].rvalid;
      assign rdata_a[k]   = m[k].rdata;
      assign rresp_a[k]   = m[k].rresp;
      assign m[k].awvalid = aw_req && widx == IDX_W'(k);
      assign m[k].awaddr  = waddr;
      assign m[k].wvalid  = w_req && widx == IDX_W'(k);
      assign m[k].wdata   = wdata;
      assign m[k].wstrb   = wstrb;
      assign m[k].bready  = !b_wait || widx == IDX_W'(k);
      assign m[k].arvalid = ar_req && ridx == IDX_W'(k);
      assign m[k].araddr  = raddr;
      assign m[k].rready  = !r_wait || ridx == IDX_W'(k);
    end else begin : g_off
      assign awready_v[k] = 1'b0;
      assign wready_v[k]  = 1'b0;
      assign bvalid_v[k]  = 1'b0;
      assign bresp_a[k]   = OKAY;
      assign arready_v[k] = 1'b0;
      assign rvalid_v[k]  = 1'b0;
      assign rdata_a[k]   = '0;
      assign rresp_a[k]   = OKAY;
    end
  end

endmodule

// File: tb/tb_axi4l_decoder.sv
// Directed bench for axi4l_decoder with four zero-wait slave models.
// Timeout scenario is built only with AXI4L_DECODER_TIMEOUT_EN.
module tb_axi4l_decoder;
  import axi4l_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4l_if s_if ();
  axi4l_if m_if [4] ();

  axi4l_decoder #(
    .N(4), .BASE(32'h8000_0000), .TIMEOUT(8)
  ) dut (
    .aclk(clk), .areset(rst), .s(s_if), .m(m_if)
  );

  logic [3:0] mute = '0;
  logic [3:0] kick = '0;
  logic [3:0] led  = '0;
  logic [3:0] awv, wv, arv, brd;
  int n_chk  = 0;
  int n_pass = 0;
  int a0;
  logic seen;

  for (genvar k = 0; k < 4; k++) begin : g_slv
    logic bv = 1'b0;
    logic rv = 1'b0;
    logic [31:0] wdata_q = '0;
    int aw_n = 0;
    int w_n  = 0;
    int ar_n = 0;
    assign m_if[k].awready = 1'b1;
    assign m_if[k].wready  = 1'b1;
    assign m_if[k].arready = 1'b1;
    assign m_if[k].bvalid  = bv;
    assign m_if[k].bresp   = OKAY;
    assign m_if[k].rvalid  = rv;
    assign m_if[k].rresp   = OKAY;
    assign m_if[k].rdata   = (k == 1) ? 32'hDEAD_BEEF
                           : 32'(32'h1000_0000 + k);
    assign awv[k] = m_if[k].awvalid;
    assign wv[k]  = m_if[k].wvalid;
    assign arv[k] = m_if[k].arvalid;
    assign brd[k] = m_if[k].bready;
    always @(posedge clk) begin
      if (m_if[k].awvalid) aw_n <= aw_n + 1;
      if (m_if[k].wvalid) begin
        w_n     <= w_n + 1;
        wdata_q <= m_if[k].wdata;
      end
      if (m_if[k].arvalid) ar_n <= ar_n + 1;
      if (m_if[k].awvalid && !mute[k]) bv <= 1'b1;
      else if (kick[k]) bv <= 1'b1;
      else if (m_if[k].bready) bv <= 1'b0;
      if (m_if[k].arvalid) rv <= 1'b1;
      else if (m_if[k].rready) rv <= 1'b0;
    end
  end

  always @(posedge clk)
    if (m_if[0].wvalid) led <= m_if[0].wdata[3:0];

  function automatic int act();
    return g_slv[0].aw_n + g_slv[0].w_n + g_slv[0].ar_n
         + g_slv[1].aw_n + g_slv[1].w_n + g_slv[1].ar_n
         + g_slv[2].aw_n + g_slv[2].w_n + g_slv[2].ar_n
         + g_slv[3].aw_n + g_slv[3].w_n + g_slv[3].ar_n;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic put_wr(input logic [31:0] a, input logic [31:0] d);
    s_if.awaddr  = a;
    s_if.awvalid = 1'b1;
    s_if.wdata   = d;
    s_if.wstrb   = 4'hf;
    s_if.wvalid  = 1'b1;
  endtask

  initial begin
    s_if.awvalid = 1'b0;
    s_if.awaddr  = '0;
    s_if.wvalid  = 1'b0;
    s_if.wdata   = '0;
    s_if.wstrb   = '0;
    s_if.bready  = 1'b0;
    s_if.arvalid = 1'b0;
    s_if.araddr  = '0;
    s_if.rready  = 1'b0;
    repeat (3) @(posedge clk);
    mid();
    check("rst_ready", {s_if.awready, s_if.wready, s_if.arready}, 3'b111);
    check("rst_sval", {s_if.bvalid, s_if.rvalid}, 2'b00);
    check("rst_mval", {awv, wv, arv}, 12'h000);
    check("rst_bready", brd, 4'hf);
    check("rst_resp", {s_if.bresp, s_if.rresp, s_if.rdata}, 36'h0);

    // write 0x5 to the LED slave
    go();
    rst = 1'b0;
    s_if.bready = 1'b1;
    s_if.rready = 1'b1;
    put_wr(32'h8000_0000, 32'h5);
    mid();
    check("wr_c0_rdy", {s_if.awready, s_if.wready}, 2'b11);
    go();
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;
    mid();
    check("wr_c1_mval", {awv, wv}, 8'h11);
    check("wr_c1_addr", m_if[0].awaddr, 32'h8000_0000);
    check("wr_c1_data", m_if[0].wdata, 32'h5);
    check("wr_c1_busy", {s_if.awready, s_if.wready}, 2'b00);
    go(); mid();
    check("wr_c2", {m_if[0].bvalid, s_if.bvalid}, 2'b10);
    go(); mid();
    check("wr_c3", {s_if.bvalid, s_if.bresp}, {1'b1, OKAY});
    go(); mid();
    check("wr_c4", {s_if.bvalid, s_if.awready}, 2'b01);
    check("led", led, 4'h5);

    // read from m[1]
    go();
    s_if.araddr  = 32'h8000_1004;
    s_if.arvalid = 1'b1;
    mid();
    check("rd_c0_rdy", s_if.arready, 1'b1);
    go();
    s_if.arvalid = 1'b0;
    mid();
    check("rd_c1_arv", arv, 4'b0010);
    check("rd_c1_addr", m_if[1].araddr, 32'h8000_1004);
    go(); mid();
    check("rd_c2", s_if.rvalid, 1'b0);
    go(); mid();
    check("rd_c3", {s_if.rvalid, s_if.rresp, s_if.rdata},
          {1'b1, OKAY, 32'hDEAD_BEEF});
    check("rd_others",
          g_slv[0].ar_n + g_slv[2].ar_n + g_slv[3].ar_n, 0);

    // unmapped write and read together
    go();
    a0 = act();
    put_wr(32'h8000_F000, 32'h1234);
    s_if.araddr  = 32'h9000_0000;
    s_if.arvalid = 1'b1;
    mid();
    go();
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;
    s_if.arvalid = 1'b0;
    mid();
    check("dec_b", {s_if.bvalid, s_if.bresp}, {1'b1, DECERR});
    check("dec_r", {s_if.rvalid, s_if.rresp, s_if.rdata},
          {1'b1, DECERR, 32'h0});
    check("dec_mval", {awv, wv, arv}, 12'h000);
    check("dec_act", act() - a0, 0);

    // W first, AW two cycles later, master stalls B
    go();
    s_if.bready  = 1'b0;
    s_if.wdata   = 32'hA;
    s_if.wstrb   = 4'hf;
    s_if.wvalid  = 1'b1;
    s_if.awaddr  = 32'h8000_0000;
    mid();
    go();
    s_if.wvalid = 1'b0;
    mid();
    check("ooo_c1_rdy", {s_if.awready, s_if.wready}, 2'b10);
    check("ooo_c1_mval", {awv, wv}, 8'h00);
    go();
    s_if.awvalid = 1'b1;
    mid();
    go();
    s_if.awvalid = 1'b0;
    mid();
    check("ooo_c3_mval", {awv, wv}, 8'h11);
    check("ooo_c3_data", m_if[0].wdata, 32'hA);
    go(); mid();
    for (int i = 0; i < 3; i++) begin
      go(); mid();
      check("ooo_bhold", {s_if.bvalid, s_if.bresp, s_if.awready},
            {1'b1, OKAY, 1'b0});
    end
    go();
    s_if.bready = 1'b1;
    mid();
    check("ooo_hs", {s_if.bvalid, s_if.awready}, 2'b10);
    go(); mid();
    check("ooo_idle", {s_if.bvalid, s_if.awready}, 2'b01);
    check("ooo_led", led, 4'hA);

    // concurrent read/write to m[2], reset while in W_RESP
    go();
    mute = 4'b0100;
    put_wr(32'h8000_2000, 32'h77);
    s_if.araddr  = 32'h8000_2008;
    s_if.arvalid = 1'b1;
    mid();
    go();
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;
    s_if.arvalid = 1'b0;
    mid();
    check("cc_c1", {awv, arv}, 8'h44);
    go(); mid();
    go(); mid();
    check("cc_rd", {s_if.rvalid, s_if.rdata}, {1'b1, 32'h1000_0002});
    check("cc_wait", {s_if.bvalid, brd}, 5'b0_0100);
    go();
    rst = 1'b1;
    mid();
    go();
    rst = 1'b0;
    mute = 4'b0000;
    mid();
    check("rst_mid_s", {s_if.bvalid, s_if.rvalid, s_if.awready}, 3'b001);
    check("rst_mid_m", {awv, wv, arv, brd}, 16'h000f);
    go();
    put_wr(32'h8000_2000, 32'h99);
    mid();
    go();
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;
    mid();
    go(); mid();
    go(); mid();
    check("post_rst_b", {s_if.bvalid, s_if.bresp}, {1'b1, OKAY});
    check("post_rst_d", g_slv[2].wdata_q, 32'h99);
    go(); mid();

`ifdef AXI4L_DECODER_TIMEOUT_EN
    // m[3] never answers; watchdog returns SLVERR
    go();
    mute = 4'b1000;
    put_wr(32'h8000_3000, 32'h3);
    mid();
    go();
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;
    mid();
    seen = s_if.bvalid;
    for (int i = 2; i <= 8; i++) begin
      go(); mid();
      seen = seen | s_if.bvalid;
    end
    check("to_early", seen, 1'b0);
    go(); mid();
    check("to_slverr", {s_if.bvalid, s_if.bresp}, {1'b1, SLVERR});
    go();
    kick = 4'b1000;
    mid();
    check("to_done", s_if.bvalid, 1'b0);
    go();
    kick = 4'b0000;
    mid();
    check("to_drain", {m_if[3].bvalid, m_if[3].bready, s_if.bvalid},
          3'b110);
    go(); mid();
    check("to_quiet", {m_if[3].bvalid, s_if.bvalid}, 2'b00);
    mute = 4'b0000;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
